// File: rtl/sram_responder_if.sv
// Device-side view of the asynchronous-SRAM pin bundle: address, strobes and
// split data lanes; the top level builds the physical inout from dout/dout_en.
interface sram_responder_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              en_n;
  logic              oe_n;
  logic              we_n;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_en;

  modport master (
    output addr, en_n, oe_n, we_n, din,
    input  dout, dout_en
  );

  modport slave (
    input  addr, en_n, oe_n, we_n, din,
    output dout, dout_en
  );
endinterface

// File: rtl/sram_responder.sv
// Emulates an asynchronous SRAM chip on top of an internal synchronous RAM,
// with conflict detection and access counters. Optional: SRAM_RESP_WRPROT_EN.
module sram_responder #(
  parameter int                ADDR_W   = 18,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH_W  = 10,
  parameter logic [ADDR_W-1:0] WP_LIMIT = 'h00100
) (
  input  logic        clk,
  input  logic        rst,
  sram_responder_if.slave bus,
  output logic        conflict,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        wp_hit
);

`ifdef SRAM_RESP_WRPROT_EN
  localparam bit WrProtEn = 1'b1;
`else
  localparam bit WrProtEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT} state_t;

  state_t state;

  // Single sampling stage: the pins are asynchronous to clk.
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic              s_en_n;
  logic              s_oe_n;
  logic              s_we_n;

  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_din;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] dout_q;
  logic              dout_en_q;

  logic [DATA_W-1:0] mem [2**DEPTH_W];

  logic wr_req;
  logic rd_req;
  logic rd_hold;
  logic wr_end;
  logic wr_blocked;
  logic mem_we;
  logic rd_issue;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    rd_hold    = 1'b0;
    wr_end     = 1'b0;
    wr_blocked = 1'b0;
    mem_we     = 1'b0;
    rd_issue   = 1'b0;

    wr_req  = !s_en_n && !s_we_n;
    rd_hold = !s_en_n && !s_oe_n;
    rd_req  = rd_hold && s_we_n;

    wr_end     = (state == WR_ACT) && !wr_req;
    wr_blocked = WrProtEn && (cap_addr < WP_LIMIT);
    // Commit is combinational so the word lands on the same edge the FSM
    // leaves WR_ACT, ahead of any read issued from IDLE afterwards.
    mem_we     = wr_end && !wr_blocked && !rst;
    rd_issue   = rd_req && (state == IDLE || state == RD_ACT);
  end

  // NOTE: the backing store has no reset, so it maps onto block RAM and keeps
  // its contents across rst like a real SRAM chip.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cap_addr[DEPTH_W-1:0]] <= cap_din;
    end
    if (rd_issue) begin
      ram_q <= mem[s_addr[DEPTH_W-1:0]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_addr    <= '0;
      s_din     <= '0;
      s_en_n    <= 1'b1;
      s_oe_n    <= 1'b1;
      s_we_n    <= 1'b1;
      state     <= IDLE;
      cap_addr  <= '0;
      cap_din   <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      conflict  <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
      wp_hit    <= 1'b0;
    end else begin
      s_addr <= bus.addr;
      s_din  <= bus.din;
      s_en_n <= bus.en_n;
      s_oe_n <= bus.oe_n;
      s_we_n <= bus.we_n;

      wp_hit <= 1'b0;

      if (wr_req && !s_oe_n) begin
        conflict <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          dout_en_q <= 1'b0;
          if (wr_req) begin
            cap_addr <= s_addr;
            cap_din  <= s_din;
            state    <= WR_ACT;
          end else if (rd_req) begin
            state <= RD_ACT;
          end
        end

        WR_ACT: begin
          dout_en_q <= 1'b0;
          if (wr_req) begin
            cap_addr <= s_addr;
            cap_din  <= s_din;
          end else begin
            if (wr_blocked) begin
              wp_hit <= 1'b1;
            end else begin
              wr_count <= sat_inc(wr_count);
            end
            state <= IDLE;
          end
        end

        RD_ACT: begin
          if (wr_req) begin
            // A write strobe arriving mid-read wins: the read is closed out.
            dout_en_q <= 1'b0;
            rd_count  <= sat_inc(rd_count);
            cap_addr  <= s_addr;
            cap_din   <= s_din;
            state     <= WR_ACT;
          end else if (rd_hold) begin
            dout_q    <= ram_q;
            dout_en_q <= 1'b1;
          end else begin
            dout_en_q <= 1'b0;
            rd_count  <= sat_inc(rd_count);
            state     <= IDLE;
          end
        end

        default: begin
          dout_en_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout    = dout_q;
  assign bus.dout_en = dout_en_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed and randomized bus accesses against an array-based SRAM model.
module tb_sram_responder;

`ifdef SRAM_RESP_WRPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        conflict;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        wp_hit;

  sram_responder_if #(.ADDR_W(18), .DATA_W(16)) bus ();

  sram_responder dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .conflict (conflict),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .wp_hit   (wp_hit)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_m [1024];
  bit          valid_m [1024];
  int          idx_q[$];
  int          rd_m = 0;
  int          wr_m = 0;
  bit          conflict_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.en_n = 1'b1;
    bus.oe_n = 1'b1;
    bus.we_n = 1'b1;
  endtask

  task automatic bus_write(input logic [17:0] addr, input logic [15:0] d_first,
                           input logic [15:0] d_last, input int hold, input bit oe_low);
    bit prot;
    int idx;
    prot = WP && (addr < 18'h00100);
    idx  = int'(addr[9:0]);
    @(negedge clk);
    bus.addr = addr;
    bus.din  = d_first;
    bus.en_n = 1'b0;
    bus.we_n = 1'b0;
    bus.oe_n = !oe_low;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      check("wr_dout_en", 32'(bus.dout_en), 32'd0);
      if (k == hold / 2) bus.din = d_last;
    end
    bus_idle();
    if (oe_low) conflict_m = 1'b1;
    if (!prot) begin
      mem_m[idx] = d_last;
      if (!valid_m[idx]) idx_q.push_back(idx);
      valid_m[idx] = 1'b1;
      if (wr_m < 65535) wr_m++;
    end
    @(negedge clk);
    @(negedge clk);
    check("wp_hit_commit", 32'(wp_hit), 32'(prot));
    check("wr_count", 32'(wr_count), 32'(wr_m));
    check("conflict", 32'(conflict), 32'(conflict_m));
    @(negedge clk);
    check("wp_hit_after", 32'(wp_hit), 32'd0);
  endtask

  task automatic bus_read(input logic [17:0] addr, input int hold);
    logic [15:0] exp;
    exp = mem_m[addr[9:0]];
    @(negedge clk);
    bus.addr = addr;
    bus.en_n = 1'b0;
    bus.oe_n = 1'b0;
    bus.we_n = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      check("rd_dout_en", 32'(bus.dout_en), 32'(k >= 3));
      if (k >= 3) check("rd_dout", 32'(bus.dout), 32'(exp));
    end
    bus_idle();
    if (rd_m < 65535) rd_m++;
    @(negedge clk);
    @(negedge clk);
    check("rd_dout_en_drop", 32'(bus.dout_en), 32'd0);
    check("rd_count", 32'(rd_count), 32'(rd_m));
    @(negedge clk);
  endtask

  initial begin
    logic [17:0] a;
    int          idx;

    rst      = 1'b1;
    bus.addr = '0;
    bus.din  = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_dout_en", 32'(bus.dout_en), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_wp_hit", 32'(wp_hit), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read-back, 3-cycle read latency.
    bus_write(18'h00200, 16'hBEEF, 16'hBEEF, 4, 1'b0);
    bus_read(18'h00200, 6);

    // Last data before WE rises wins.
    bus_write(18'h00300, 16'h1111, 16'h2222, 4, 1'b0);
    bus_read(18'h00300, 4);

    // Upper address bits alias onto the same word.
    bus_write(18'h00405, 16'hA5A5, 16'hA5A5, 3, 1'b0);
    bus_read(18'h00005, 4);

    // OE, WE and EN low together: write wins, conflict is sticky.
    bus_write(18'h00600, 16'h1234, 16'h1234, 4, 1'b1);
    repeat (3) @(negedge clk);
    check("conflict_sticky", 32'(conflict), 32'd1);
    bus_read(18'h00600, 4);

    // Reset during a write discards it and clears counters and conflict.
    bus_write(18'h00500, 16'h0123, 16'h0123, 3, 1'b0);
    @(negedge clk);
    bus.addr = 18'h00500;
    bus.din  = 16'h7777;
    bus.en_n = 1'b0;
    bus.we_n = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_m       = 0;
    wr_m       = 0;
    conflict_m = 1'b0;
    check("abort_conflict", 32'(conflict), 32'd0);
    check("abort_wr_count", 32'(wr_count), 32'd0);
    check("abort_rd_count", 32'(rd_count), 32'd0);
    check("abort_dout_en", 32'(bus.dout_en), 32'd0);
    bus_read(18'h00500, 4);

    // Write to a low address: dropped when protection is compiled in.
    bus_write(18'h00410, 16'h5A5A, 16'h5A5A, 3, 1'b0);
    bus_write(18'h00010, 16'hFFFF, 16'hFFFF, 3, 1'b0);
    bus_read(18'h00010, 4);

    // Randomized mix of writes and reads against the model.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0 || idx_q.size() == 0) begin
        a = 18'($urandom_range(0, 18'h3FFFF));
        bus_write(a, 16'($urandom), 16'($urandom), int'($urandom_range(2, 5)), 1'b0);
      end else begin
        idx = idx_q[$urandom_range(0, idx_q.size() - 1)];
        a   = 18'(($urandom_range(0, 255) << 10) | idx);
        bus_read(a, int'($urandom_range(3, 6)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
